// File: rtl/action_frame_tx.sv
// action_frame_tx
//   Buffers approved actions from the risk limiter and serializes each one
//   into an 11-byte order frame on a byte-wide valid/ready stream.
//   Frame: SOF, {7'b0,side}, price[31:0] BE, qty[31:0] BE, XOR checksum.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid              single-cycle action strobe (no backpressure)
//   in_side/price/qty     action fields, captured when written
//   tx_data/valid/last    frame byte stream; tx_last marks the checksum byte
//   tx_ready              sink accepts the current byte
//   busy                  frame in flight or actions queued
//   fifo_level            queued actions, excluding the frame being sent
//   drop_count            saturating count of actions lost to a full FIFO
module action_frame_tx #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SOF_BYTE   = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_side,
  input  logic [31:0]                   in_price,
  input  logic [31:0]                   in_qty,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          tx_last,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam int         LW       = AW + 1;
  localparam logic [AW:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [3:0] LAST_IDX = 4'd10;

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [87:0] build_frame(input logic        side,
                                              input logic [31:0] price,
                                              input logic [31:0] qty);
    logic [79:0] body;
    logic [7:0]  cs;
    body = {SOF_BYTE, 7'b0, side, price, qty};
    cs   = '0;
    for (int i = 0; i < 10; i++) cs ^= body[i*8 +: 8];
    return {body, cs};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [87:0]    frame_q, frame_d;
  logic           tx_valid_q, tx_valid_d;
  logic           tx_last_q, tx_last_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    level_q, level_d;
  logic [15:0]    drop_q, drop_d;
  logic [64:0]    mem_q [FIFO_DEPTH];
  logic [64:0]    head;
  logic           wr_en, pop, load, hs;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    rd_ptr_d   = rd_ptr_q;
    pop        = 1'b0;
    load       = 1'b0;
    hs         = tx_valid_q & tx_ready;
    // Full is judged on the registered level, so a same-cycle pop never
    // makes room for the incoming write.
    wr_en      = in_valid & (level_q < DEPTH_L);

    case (state_q)
      IDLE: if (level_q != '0) load = 1'b1;
      SEND: begin
        if (hs) begin
          if (idx_q != LAST_IDX) begin
            // The current byte always sits in the top of the frame register.
            idx_d     = idx_q + 4'd1;
            frame_d   = {frame_q[79:0], 8'h00};
            tx_last_d = (idx_q == LAST_IDX - 4'd1);
          end else if (level_q != '0) begin
            load = 1'b1;  // back-to-back frame, no idle cycle
          end else begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            frame_d    = '0;
            idx_d      = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pop        = 1'b1;
      rd_ptr_d   = rd_ptr_q + AW'(1);
      frame_d    = build_frame(head[64], head[63:32], head[31:0]);
      idx_d      = '0;
      tx_valid_d = 1'b1;
      tx_last_d  = 1'b0;
      state_d    = SEND;
    end

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;

    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    drop_d = (in_valid & ~wr_en) ? sat_inc(drop_q) : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      frame_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_q     <= drop_d;
    end
  end

  // Action storage holds data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {in_side, in_price, in_qty};
  end

  assign tx_data    = frame_q[87:80];
  assign tx_valid   = tx_valid_q;
  assign tx_last    = tx_last_q;
  assign busy       = (state_q == SEND) | (level_q != '0);
  assign fifo_level = level_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_action_frame_tx.sv
module tb_action_frame_tx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_side = 1'b0;
  logic [31:0] in_price = '0;
  logic [31:0] in_qty = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_last;
  logic        busy;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;

  action_frame_tx #(.FIFO_DEPTH(DEPTH), .SOF_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_side(in_side),
    .in_price(in_price), .in_qty(in_qty), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  bit rand_rdy = 1'b0;

  logic [8:0] exp_q[$];   // {last, data}
  logic [7:0] cap_q[$];   // every byte accepted by the sink

  // Reference model state: queued count, frame in flight, bytes remaining
  int          m_level = 0;
  bit          m_send  = 1'b0;
  int          m_left  = 0;
  logic [15:0] m_drop  = '0;
  int          pre;
  bit          acc, mpop;

  logic [7:0] buy_ref  [11] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34,
                                8'h00, 8'h00, 8'h00, 8'h0A, 8'h89};
  logic [7:0] sell_ref [11] = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04,
                                8'h05, 8'h06, 8'h07, 8'h08, 8'hAC};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_errs++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic void push_frame(input bit s, input logic [31:0] p, input logic [31:0] q);
    logic [7:0] b [11];
    logic [7:0] cs;
    b[0] = 8'hA5;     b[1] = {7'b0, s};
    b[2] = p[31:24];  b[3] = p[23:16];  b[4] = p[15:8];  b[5] = p[7:0];
    b[6] = q[31:24];  b[7] = q[23:16];  b[8] = q[15:8];  b[9] = q[7:0];
    cs = 8'h00;
    for (int i = 0; i < 10; i++) cs = cs ^ b[i];
    b[10] = cs;
    for (int i = 0; i < 11; i++) exp_q.push_back({(i == 10), b[i]});
  endfunction

  // Behavioural model: accepts unless 8 are already queued; a frame starts
  // whenever the sender is free (or finishing) and something is queued.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level = 0; m_send = 1'b0; m_left = 0; m_drop = '0;
      exp_q.delete();
    end else begin
      pre  = m_level;
      acc  = in_valid && (pre < DEPTH);
      mpop = 1'b0;
      if (in_valid && !acc && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      if (acc) push_frame(in_side, in_price, in_qty);
      if (!m_send) begin
        if (pre > 0) begin mpop = 1'b1; m_send = 1'b1; m_left = 11; end
      end else if (tx_ready) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (pre > 0) begin mpop = 1'b1; m_left = 11; end
          else m_send = 1'b0;
        end
      end
      m_level = pre + int'(acc) - int'(mpop);
    end
  end

  // Monitor / scoreboard
  bit         prev_stall = 1'b0;
  logic [7:0] prev_d = '0;
  logic       prev_l = 1'b0;
  logic [8:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("tx_valid", 32'(tx_valid), 32'(m_send));
      chk("fifo_level", 32'(fifo_level), 32'(m_level));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      chk("busy", 32'(busy), 32'(m_send || (m_level != 0)));
      if (prev_stall) begin
        chk("stall_data", 32'(tx_data), 32'(prev_d));
        chk("stall_last", 32'(tx_last), 32'(prev_l));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e[7:0]));
          chk("tx_last", 32'(tx_last), 32'(e[8]));
        end
        cap_q.push_back(tx_data);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_d = tx_data;
      prev_l = tx_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse(input bit s, input logic [31:0] p, input logic [31:0] q);
    in_valid = 1'b1; in_side = s; in_price = p; in_qty = q;
    tick();
  endtask

  task automatic wait_idle(input int max, input string nm);
    int n = 0;
    while ((busy || tx_valid) && n < max) begin tick(); n++; end
    if (n >= max) timeout(nm);
  endtask

  task automatic cmp_frame(input string nm, input logic [7:0] r [11]);
    chk({nm, "_len"}, 32'(cap_q.size()), 32'd11);
    for (int i = 0; i < 11 && i < cap_q.size(); i++)
      chk({nm, "_byte"}, 32'(cap_q[i]), 32'(r[i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_last", 32'(tx_last), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fifo_level", 32'(fifo_level), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // BUY frame with first-byte latency
    tx_ready = 1'b1;
    cap_q.delete();
    pulse(1'b0, 32'h0000_1234, 32'h0000_000A);
    chk("lat_edge_n", 32'(tx_valid), 0);
    tick();
    chk("lat_edge_n1", 32'(tx_valid), 1);
    wait_idle(100, "buy_drain");
    cmp_frame("buy", buy_ref);

    // SELL frame
    cap_q.delete();
    pulse(1'b1, 32'h0102_0304, 32'h0506_0708);
    wait_idle(100, "sell_drain");
    cmp_frame("sell", sell_ref);

    // Two back-to-back pulses: 22 contiguous bytes
    pulse(1'b0, 32'hDEAD_BEEF, 32'h0000_0001);
    pulse(1'b1, 32'h1111_2222, 32'h3333_4444);
    for (int i = 0; i < 22; i++) begin
      chk("b2b_valid", 32'(tx_valid), 1);
      chk("b2b_last", 32'(tx_last), 32'((i == 10) || (i == 21)));
      tick();
    end
    chk("b2b_end_valid", 32'(tx_valid), 0);

    // Overflow while stalled
    tx_ready = 1'b0;
    cap_q.delete();
    for (int i = 0; i < 10; i++) pulse(i[0], 32'(i + 100), 32'(i * 3));
    tick(); tick();
    chk("ovf_level", 32'(fifo_level), 8);
    chk("ovf_drop", 32'(drop_count), 1);
    chk("ovf_loaded", 32'(tx_valid), 1);
    tx_ready = 1'b1;
    wait_idle(400, "ovf_drain");
    chk("ovf_bytes", 32'(cap_q.size()), 99);

    // SELL frame under random backpressure
    rand_rdy = 1'b1;
    cap_q.delete();
    pulse(1'b1, 32'h0102_0304, 32'h0506_0708);
    wait_idle(600, "stall_drain");
    rand_rdy = 1'b0;
    tx_ready = 1'b1;
    cmp_frame("stall_sell", sell_ref);

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b1;
        in_side  = 1'($urandom_range(0, 1));
        in_price = $urandom;
        in_qty   = $urandom;
      end
      tick();
    end
    rand_rdy = 1'b0;
    tx_ready = 1'b1;
    wait_idle(3000, "rand_drain");
    chk("rand_sb_empty", 32'(exp_q.size()), 0);

    // Reset in the middle of a frame with 3 queued
    cap_q.delete();
    pulse(1'b0, 32'hA, 32'h1);
    pulse(1'b1, 32'hB, 32'h2);
    pulse(1'b0, 32'hC, 32'h3);
    pulse(1'b1, 32'hD, 32'h4);
    begin
      int n = 0;
      while (cap_q.size() < 4 && n < 50) begin tick(); n++; end
      if (n >= 50) timeout("midrst_wait");
    end
    chk("midrst_level_pre", 32'(fifo_level), 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    chk("midrst_tx_last", 32'(tx_last), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_level", 32'(fifo_level), 0);
    chk("midrst_drop", 32'(drop_count), 0);
    tick(); tick();
    rst_n = 1'b1;
    cap_q.delete();
    for (int i = 0; i < 20; i++) tick();
    chk("post_rst_bytes", 32'(cap_q.size()), 0);
    chk("post_rst_level", 32'(fifo_level), 0);
    chk("post_rst_drop", 32'(drop_count), 0);
    pulse(1'b0, 32'h0000_1234, 32'h0000_000A);
    wait_idle(100, "post_rst_drain");
    cmp_frame("post_rst_buy", buy_ref);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/action_frame_tx.md
Name: action_frame_tx

Overview:
- Sits downstream of the risk limiter and consumes its approved-action outputs: one-cycle valid pulses carrying side, price and qty, with no backpressure.
- Buffers actions in a small FIFO and serializes each one into an 11-byte order frame on a byte-wide valid/ready stream toward the exchange-facing TX path (UART/ETH MAC shim).
- Counts actions dropped on FIFO overflow.

Parameters:
- FIFO_DEPTH, 8, action FIFO entries; must be a power of 2, minimum 2.
- SOF_BYTE, 8'hA5, start-of-frame byte.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  approved action strobe, single-cycle, no ready
- in_side  in  1  0 = BUY, 1 = SELL
- in_price  in  32  price
- in_qty  in  32  quantity
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts the byte
- tx_last  out  1  high on the final (checksum) byte
- busy  out  1  frame in flight or FIFO non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  stored entries; excludes the frame being sent
- drop_count  out  16  saturating count of dropped actions

Behaviour:
- Reset (async assert): tx_valid=0, tx_last=0, tx_data=0, busy=0, fifo_level=0, drop_count=0. FIFO pointers clear, FSM goes to IDLE. A partial frame is abandoned and never resumed.
- Frame layout, sent in byte order, multi-byte fields big-endian:
  - byte 0: SOF_BYTE
  - byte 1: {7'b0, side}
  - bytes 2-5: price[31:0]
  - bytes 6-9: qty[31:0]
  - byte 10: checksum = XOR of bytes 0-9
- FIFO write:
  - Write on in_valid when registered fifo_level < FIFO_DEPTH.
  - Full is evaluated on the pre-pop level: a pop in the same cycle does not free space for that write.
  - In-valid while full: action dropped, drop_count += 1, saturating at 16'hFFFF.
  - Simultaneous write and pop with level < DEPTH: level unchanged.
- FSM, states IDLE and SEND, all outputs registered:
  - IDLE: if fifo_level > 0, pop head, compute checksum, load the 11-byte frame register, set idx=0, go to SEND. tx_valid rises the next cycle.
  - SEND: tx_valid=1, tx_data=frame[idx], tx_last=(idx==10).
    - Handshake (tx_valid & tx_ready) with idx<10: idx+1.
    - Handshake with idx==10 and FIFO non-empty: pop and load the next frame in the same edge, stay in SEND. No bubble between frames.
    - Handshake with idx==10 and FIFO empty: go to IDLE; tx_valid and tx_last drop.
  - While tx_valid & !tx_ready: tx_data, tx_last and idx are held stable.
- Latency: in_valid at edge N with empty FIFO and IDLE → entry stored at N; first byte tx_valid=1 after edge N+1.
- Throughput: 1 byte per cycle when tx_ready is held high; 11 cycles per action.
- busy = (state==SEND) | (fifo_level != 0).
- Values captured at write are immutable; later in_* changes do not affect queued frames.

Test Plan:
- BUY, price 0x00001234, qty 0x0000000A, tx_ready=1 → A5 00 00 00 12 34 00 00 00 0A 89. tx_last only on 0x89. First tx_valid 2 cycles after the pulse.
- SELL, price 0x01020304, qty 0x05060708 → A5 01 01 02 03 04 05 06 07 08 AC.
- Two pulses on consecutive cycles, tx_ready=1 → 22 contiguous valid bytes, tx_last at bytes 11 and 22, no gap cycle.
- tx_ready=0, 10 pulses on consecutive cycles, DEPTH=8:
  - One frame is loaded; fifo_level=8; drop_count=1.
  - Release tx_ready → exactly 9 frames sent in order.
- Random tx_ready toggling on the sell frame → tx_data and tx_last stable while stalled; byte sequence identical to the sell case above.
- rst_n pulsed low at byte 4 of a frame with 3 queued → outputs 0 immediately. After release: no bytes, fifo_level=0, drop_count=0. A new pulse then yields a fresh full frame.
